// File: rtl/fp64_seq_pkg.sv
// Shared types and constants for the fp64 multiplier word sequencer.
// Field constants are also used by the optional FP64_SEQ_FLAGS_EN classifier.
package fp64_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        SEND_LO,
        SEND_HI
    } seq_state_e;

    // Operand word order on the input stream
    localparam logic [1:0] IDX_A_LO = 2'd0;
    localparam logic [1:0] IDX_A_HI = 2'd1;
    localparam logic [1:0] IDX_B_LO = 2'd2;
    localparam logic [1:0] IDX_B_HI = 2'd3;

    // IEEE-754 binary64 field layout
    localparam int unsigned EXP_MSB  = 62;
    localparam int unsigned EXP_LSB  = 52;
    localparam int unsigned MAN_W    = 52;
    localparam logic [10:0] EXP_ONES = 11'h7FF;

    // Bit positions within m_flags
    localparam int unsigned NAN  = 3;
    localparam int unsigned INF  = 2;
    localparam int unsigned ZERO = 1;
    localparam int unsigned SUB  = 0;

endpackage

// File: rtl/fp64_mul_word_sequencer_if.sv
// Stream, multiplier and status signals of the fp64 multiplier word sequencer.
// m_flags exists only when FP64_SEQ_FLAGS_EN is defined.
// slave: the sequencer itself. master: the surrounding environment.
interface fp64_mul_word_sequencer_if;

    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] mul_product;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        busy;
`ifdef FP64_SEQ_FLAGS_EN
    logic [3:0]  m_flags;
`endif

    modport slave (
        input  s_data, s_valid, mul_product, m_ready,
        output s_ready, op_a, op_b, m_data, m_valid, m_last, busy
`ifdef FP64_SEQ_FLAGS_EN
        , output m_flags
`endif
    );

    modport master (
        output s_data, s_valid, mul_product, m_ready,
        input  s_ready, op_a, op_b, m_data, m_valid, m_last, busy
`ifdef FP64_SEQ_FLAGS_EN
        , input m_flags
`endif
    );

endinterface

// File: rtl/fp64_classify.sv
// Combinational binary64 classifier: flags = {nan, inf, zero, subnormal}.
// Only instantiated when FP64_SEQ_FLAGS_EN is defined.
module fp64_classify
    import fp64_seq_pkg::*;
(
    input  logic [63:0] value,
    output logic [3:0]  flags
);

    logic [10:0]      exp_field;
    logic [MAN_W-1:0] man_field;
    logic             unused_sign;

    assign exp_field   = value[EXP_MSB:EXP_LSB];
    assign man_field   = value[MAN_W-1:0];
    // Sign does not affect the class
    assign unused_sign = value[63];

    // Decode exponent/mantissa extremes into class flags
    always_comb begin
        flags       = '0;
        flags[NAN]  = (exp_field == EXP_ONES) && (man_field != '0);
        flags[INF]  = (exp_field == EXP_ONES) && (man_field == '0);
        flags[ZERO] = (exp_field == '0) && (man_field == '0);
        flags[SUB]  = (exp_field == '0) && (man_field != '0);
    end

endmodule

// File: rtl/fp64_mul_word_sequencer.sv
// Word sequencer around a combinational fp64 multiplier: collects four 32-bit
// operand words into op_a/op_b, waits MUL_LAT cycles, captures the product and
// returns it as a low word then a high (m_last) word.
// Optional FP64_SEQ_FLAGS_EN adds m_flags = {nan, inf, zero, subnormal} of the result.
module fp64_mul_word_sequencer
    import fp64_seq_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1,  // 1..15
    parameter int unsigned WORD_W  = 32  // must be 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fp64_mul_word_sequencer_if.slave   bus
);

    localparam logic [3:0] LAT = 4'(MUL_LAT);

    seq_state_e  state;
    logic [1:0]  idx;
    logic [3:0]  cnt;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] result;
    logic        s_ready;
    logic        m_valid;
    logic        m_last;
    logic        busy;
    logic        capture;

    // Counter is about to expire: the product has settled for MUL_LAT cycles
    assign capture = (state == WAIT) && (cnt == 4'd1);

    // Control FSM with registered handshake outputs and operand/result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            result  <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state   <= LOAD;
                    s_ready <= 1'b1;
                end
                LOAD: begin
                    // s_ready is held high for the whole of LOAD
                    if (bus.s_valid) begin
                        unique case (idx)
                            IDX_A_LO: op_a[WORD_W-1:0]        <= bus.s_data;
                            IDX_A_HI: op_a[2*WORD_W-1:WORD_W] <= bus.s_data;
                            IDX_B_LO: op_b[WORD_W-1:0]        <= bus.s_data;
                            IDX_B_HI: op_b[2*WORD_W-1:WORD_W] <= bus.s_data;
                        endcase
                        idx  <= idx + 2'd1;
                        busy <= 1'b1;
                        if (idx == IDX_B_HI) begin
                            state   <= WAIT;
                            cnt     <= LAT;
                            s_ready <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (capture) begin
                        result  <= bus.mul_product;
                        cnt     <= '0;
                        m_valid <= 1'b1;
                        state   <= SEND_LO;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SEND_LO: begin
                    if (bus.m_ready) begin
                        m_last <= 1'b1;
                        state  <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (bus.m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        idx     <= '0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= LOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result word select; driven purely from registered state and result
    always_comb begin
        bus.m_data = '0;
        if (state == SEND_LO) begin
            bus.m_data = result[WORD_W-1:0];
        end else if (state == SEND_HI) begin
            bus.m_data = result[2*WORD_W-1:WORD_W];
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_last  = m_last;
    assign bus.busy    = busy;
    assign bus.op_a    = op_a;
    assign bus.op_b    = op_b;

`ifdef FP64_SEQ_FLAGS_EN
    logic [3:0] flags_c;
    logic [3:0] m_flags;

    fp64_classify u_classify (
        .value (bus.mul_product),
        .flags (flags_c)
    );

    // Flags are latched together with the result and held through both beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags <= '0;
        end else if (capture) begin
            m_flags <= flags_c;
        end
    end

    assign bus.m_flags = m_flags;
`endif

endmodule

// File: tb/tb_fp64_mul_word_sequencer.sv
// Self-checking bench for fp64_mul_word_sequencer with a delayed multiplier stub.
// Checks m_flags as well when FP64_SEQ_FLAGS_EN is defined.
module tb_fp64_mul_word_sequencer;

    localparam int unsigned LAT = 3;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] prod;
        logic [3:0]  flags;
        int          gap;
        int          stall;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fp64_mul_word_sequencer_if bus ();

    fp64_mul_word_sequencer #(
        .MUL_LAT (LAT),
        .WORD_W  (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Multiplier stub: known products for table operands, a fixed hash otherwise,
    // delivered LAT-1 clocks after op_a/op_b change so it is valid at the capture edge.
    logic [63:0] stub_map [logic [127:0]];
    logic [63:0] pipe [LAT-1];
    logic        force_en = 1'b0;
    logic [63:0] force_val = '0;

    function automatic logic [63:0] stub_fn(input logic [63:0] a, input logic [63:0] b);
        if (stub_map.exists({a, b})) return stub_map[{a, b}];
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ {b[31:0], b[63:32]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= stub_fn(bus.op_a, bus.op_b);
        for (int i = 1; i < int'(LAT) - 1; i++) pipe[i] <= pipe[i-1];
    end

    assign bus.mul_product = force_en ? force_val : pipe[LAT-2];

    function automatic logic [3:0] ref_flags(input logic [63:0] p);
        int unsigned e = int'(p[62:52]);
        bit frac_nz = (p[51:0] != 0);
        if (e == 2047) return frac_nz ? 4'b1000 : 4'b0100;
        if (e == 0) return frac_nz ? 4'b0001 : 4'b0010;
        return 4'b0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Push four operand words; gap idle cycles are inserted between words 1 and 2.
    // Starts and ends on a falling edge.
    task automatic load_words(input logic [63:0] a, input logic [63:0] b, input int gap);
        logic [31:0] w [4];
        int cyc;
        w = '{a[31:0], a[63:32], b[31:0], b[63:32]};
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = w[i];
            cyc = 0;
            while (bus.s_ready !== 1'b1 && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            chk("s_ready_in_load", 64'(bus.s_ready), 64'd1);
            @(negedge clk);
            bus.s_valid = 1'b0;
            if (i == 1) begin
                repeat (gap) begin
                    chk("busy_in_gap", 64'(bus.busy), 64'd1);
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic run_txn(input vec_t v);
        int cyc;
        load_words(v.a, v.b, v.gap);
        chk("op_a", bus.op_a, v.a);
        chk("op_b", bus.op_b, v.b);
        chk("busy_in_wait", 64'(bus.busy), 64'd1);
        // Offer junk while the result is pending; none of it may be taken
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hDEAD_BEEF;
        cyc = 0;
        while (bus.m_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(LAT));
        // Product moves after capture; the returned words must not follow it
        force_val = {$urandom, $urandom};
        force_en  = 1'b1;
        bus.m_ready = 1'b0;
        for (int k = 0; k < v.stall; k++) begin
            chk("stall_data", 64'(bus.m_data), 64'(v.prod[31:0]));
            chk("stall_last", 64'(bus.m_last), 64'd0);
            chk("stall_s_ready", 64'(bus.s_ready), 64'd0);
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        chk("lo_valid", 64'(bus.m_valid), 64'd1);
        chk("lo_data", 64'(bus.m_data), 64'(v.prod[31:0]));
        chk("lo_last", 64'(bus.m_last), 64'd0);
`ifdef FP64_SEQ_FLAGS_EN
        chk("lo_flags", 64'(bus.m_flags), 64'(v.flags));
`endif
        @(negedge clk);
        chk("hi_valid", 64'(bus.m_valid), 64'd1);
        chk("hi_data", 64'(bus.m_data), 64'(v.prod[63:32]));
        chk("hi_last", 64'(bus.m_last), 64'd1);
        chk("hi_s_ready", 64'(bus.s_ready), 64'd0);
`ifdef FP64_SEQ_FLAGS_EN
        chk("hi_flags", 64'(bus.m_flags), 64'(v.flags));
`endif
        @(negedge clk);
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        force_en    = 1'b0;
        chk("done_valid", 64'(bus.m_valid), 64'd0);
        chk("done_s_ready", 64'(bus.s_ready), 64'd1);
        chk("done_busy", 64'(bus.busy), 64'd0);
        chk("hold_op_a", bus.op_a, v.a);
        chk("hold_op_b", bus.op_b, v.b);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
        chk({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
        chk({tag, "_m_last"}, 64'(bus.m_last), 64'd0);
        chk({tag, "_m_data"}, 64'(bus.m_data), 64'd0);
        chk({tag, "_op_a"}, bus.op_a, 64'd0);
        chk({tag, "_op_b"}, bus.op_b, 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
`ifdef FP64_SEQ_FLAGS_EN
        chk({tag, "_m_flags"}, 64'(bus.m_flags), 64'd0);
`endif
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl [7];
        vec_t rv;
        int   quiet;

        tbl[0] = '{64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000,
                   64'h4018_0000_0000_0000, 4'b0000, 0, 0};
        tbl[1] = '{64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000,
                   64'h4018_0000_0000_0000, 4'b0000, 2, 5};
        tbl[2] = '{64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000,
                   64'h7FF8_0000_0000_0000, 4'b1000, 0, 1};
        tbl[3] = '{64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000,
                   64'h0000_0000_0000_0001, 4'b0001, 1, 0};
        tbl[4] = '{64'h0000_0000_0000_0000, 64'h4014_0000_0000_0000,
                   64'h0000_0000_0000_0000, 4'b0010, 0, 3};
        tbl[5] = '{64'h7FE0_0000_0000_0000, 64'h4000_0000_0000_0000,
                   64'h7FF0_0000_0000_0000, 4'b0100, 1, 2};
        tbl[6] = '{64'hC000_0000_0000_0000, 64'h3FE0_0000_0000_0000,
                   64'hBFF0_0000_0000_0000, 4'b0000, 3, 0};
        foreach (tbl[i]) stub_map[{tbl[i].a, tbl[i].b}] = tbl[i].prod;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        // Reset state
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("idle_s_ready", 64'(bus.s_ready), 64'd0);
        @(negedge clk);
        chk("first_load_s_ready", 64'(bus.s_ready), 64'd1);
        chk("first_load_busy", 64'(bus.busy), 64'd0);

        // Directed vectors
        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset during WAIT: everything clears at once and no result appears
        load_words(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_wait_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_s_ready", 64'(bus.s_ready), 64'd1);
        quiet = 0;
        repeat (LAT + 3) begin
            if (bus.m_valid === 1'b0) quiet++;
            @(negedge clk);
        end
        chk("no_result_after_reset", 64'(quiet), 64'(LAT + 3));
        run_txn(tbl[0]);

        // Randomized transactions against the stub-based reference
        for (int n = 0; n < 20; n++) begin
            rv.a     = {$urandom, $urandom};
            rv.b     = {$urandom, $urandom};
            rv.prod  = stub_fn(rv.a, rv.b);
            rv.flags = ref_flags(rv.prod);
            rv.gap   = int'($urandom_range(0, 3));
            rv.stall = int'($urandom_range(0, 3));
            run_txn(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
